// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between the light controller and the traffic-light monitor.
// The controller side drives the code; the monitor side returns decodes and status.
interface traffic_light_monitor_if #(
    parameter int RND_W = 16
);
    logic [1:0]       light;
    logic             red_on;
    logic             yellow_on;
    logic             green_on;
    logic             err_seq;
    logic             err_time;
    logic             err_any;
    logic [RND_W-1:0] rounds;

    modport master (
        output light,
        input  red_on, yellow_on, green_on, err_seq, err_time, err_any, rounds
    );

    modport slave (
        input  light,
        output red_on, yellow_on, green_on, err_seq, err_time, err_any, rounds
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the 2-bit traffic-light code: registered lamp decode,
// legal-sequence and dwell-time verification, and completed-round counting.
module traffic_light_monitor #(
    parameter int RED_TICKS    = 50,
    parameter int YELLOW_TICKS = 10,
    parameter int GREEN_TICKS  = 30,
    parameter int CNT_W        = 8,
    parameter int RND_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_light_monitor_if.slave tl
);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        GREEN  = 2'd3
    } code_t;

    code_t            prev, prev_n, cur;
    logic [CNT_W-1:0] dwell, dwell_n;
    logic             over, over_n;
    logic             seq_n, time_n, any_n;
    logic [RND_W-1:0] rounds_q, rounds_n;
    logic             red_q, yellow_q, green_q, seq_q, time_q, any_q;

    function automatic logic [CNT_W-1:0] limit(input code_t c);
        case (c)
            RED:     limit = CNT_W'(RED_TICKS);
            YELLOW:  limit = CNT_W'(YELLOW_TICKS);
            GREEN:   limit = CNT_W'(GREEN_TICKS);
            default: limit = '0;
        endcase
    endfunction

    function automatic logic legal(input code_t p, input code_t n);
        case (p)
            OFF:     legal = (n == RED);
            RED:     legal = (n == YELLOW) || (n == OFF);
            YELLOW:  legal = (n == GREEN)  || (n == OFF);
            GREEN:   legal = (n == RED)    || (n == OFF);
            default: legal = 1'b0;
        endcase
    endfunction

    assign cur = code_t'(tl.light);

    always_comb begin
        prev_n   = prev;
        dwell_n  = dwell;
        over_n   = over;
        seq_n    = 1'b0;
        time_n   = 1'b0;
        rounds_n = rounds_q;
        if (cur == prev) begin
            dwell_n = (dwell == '1) ? dwell : dwell + 1'b1;
            // dwell+1 == limit+1 reduces to dwell == limit since limits stay below saturation
            if (prev != OFF && !over && dwell == limit(prev)) begin
                time_n = 1'b1;
                over_n = 1'b1;
            end
        end else begin
            prev_n  = cur;
            dwell_n = CNT_W'(1);
            over_n  = 1'b0;
            if (!legal(prev, cur)) begin
                seq_n = 1'b1;
            end else if (prev != OFF && cur != OFF) begin
                if (dwell != limit(prev) && !over)
                    time_n = 1'b1;
                if (prev == GREEN && cur == RED && !time_n)
                    rounds_n = rounds_q + 1'b1;
            end
        end
        any_n = any_q | seq_n | time_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev     <= OFF;
            dwell    <= '0;
            over     <= 1'b0;
            rounds_q <= '0;
            red_q    <= 1'b0;
            yellow_q <= 1'b0;
            green_q  <= 1'b0;
            seq_q    <= 1'b0;
            time_q   <= 1'b0;
            any_q    <= 1'b0;
        end else begin
            prev     <= prev_n;
            dwell    <= dwell_n;
            over     <= over_n;
            rounds_q <= rounds_n;
            red_q    <= (cur == RED);
            yellow_q <= (cur == YELLOW);
            green_q  <= (cur == GREEN);
            seq_q    <= seq_n;
            time_q   <= time_n;
            any_q    <= any_n;
        end
    end

    assign tl.red_on    = red_q;
    assign tl.yellow_on = yellow_q;
    assign tl.green_on  = green_q;
    assign tl.err_seq   = seq_q;
    assign tl.err_time  = time_q;
    assign tl.err_any   = any_q;
    assign tl.rounds    = rounds_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; a narrow round counter exercises wrap.
module tb_traffic_light_monitor;

    localparam int RND_W = 2;
    localparam logic [1:0] C_OFF = 2'd0, C_RED = 2'd1, C_YEL = 2'd2, C_GRN = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    traffic_light_monitor_if #(.RND_W(RND_W)) tl ();

    traffic_light_monitor #(
        .RED_TICKS(50), .YELLOW_TICKS(10), .GREEN_TICKS(30), .CNT_W(8), .RND_W(RND_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tl (tl.slave)
    );

    always #5 clk = ~clk;

    // {red_on, yellow_on, green_on, err_seq, err_time, err_any}
    logic [5:0] flags;
    assign flags = {tl.red_on, tl.yellow_on, tl.green_on, tl.err_seq, tl.err_time, tl.err_any};

    task automatic step(input logic [1:0] code);
        tl.light = code;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) step(code);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(C_OFF);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tl.light = C_OFF;
        do_reset();
        compared++;
        if (flags !== 6'b000000 || tl.rounds !== 2'd0) begin
            $display("FAIL reset: flags=%b rounds=%0d want 000000/0", flags, tl.rounds);
            mismatched++;
        end
        step(C_YEL);
        compared++;
        if (flags !== 6'b010101) begin
            $display("FAIL first_yellow: flags=%b want 010101", flags);
            mismatched++;
        end
    endtask

    task automatic test_full_round();
        do_reset();
        hold(C_OFF, 5);
        step(C_RED);
        compared++;
        if (flags !== 6'b100000) begin
            $display("FAIL round_red_first: flags=%b want 100000", flags);
            mismatched++;
        end
        hold(C_RED, 49);
        hold(C_YEL, 10);
        compared++;
        if (flags !== 6'b010000) begin
            $display("FAIL round_yellow: flags=%b want 010000", flags);
            mismatched++;
        end
        hold(C_GRN, 30);
        compared++;
        if (flags !== 6'b001000 || tl.rounds !== 2'd0) begin
            $display("FAIL round_green: flags=%b rounds=%0d want 001000/0", flags, tl.rounds);
            mismatched++;
        end
        step(C_RED);
        compared++;
        if (flags !== 6'b100000 || tl.rounds !== 2'd1) begin
            $display("FAIL round_done: flags=%b rounds=%0d want 100000/1", flags, tl.rounds);
            mismatched++;
        end
    endtask

    task automatic test_seq_error();
        hold(C_RED, 49);
        step(C_GRN);
        compared++;
        if (flags !== 6'b001101) begin
            $display("FAIL seq_red_green: flags=%b want 001101", flags);
            mismatched++;
        end
        hold(C_GRN, 3);
        compared++;
        if (flags !== 6'b001001 || tl.rounds !== 2'd1) begin
            $display("FAIL seq_sticky: flags=%b rounds=%0d want 001001/1", flags, tl.rounds);
            mismatched++;
        end
    endtask

    task automatic test_dwell_red();
        do_reset();
        hold(C_RED, 49);
        step(C_YEL);
        compared++;
        if (flags !== 6'b010011) begin
            $display("FAIL short_red: flags=%b want 010011", flags);
            mismatched++;
        end
        do_reset();
        hold(C_RED, 50);
        compared++;
        if (flags !== 6'b100000) begin
            $display("FAIL red_exact50: flags=%b want 100000", flags);
            mismatched++;
        end
        step(C_RED);
        compared++;
        if (flags !== 6'b100011) begin
            $display("FAIL over_red51: flags=%b want 100011", flags);
            mismatched++;
        end
        step(C_RED);
        compared++;
        if (flags !== 6'b100001) begin
            $display("FAIL over_red52: flags=%b want 100001", flags);
            mismatched++;
        end
        step(C_YEL);
        compared++;
        if (flags !== 6'b010001) begin
            $display("FAIL over_no_repeat: flags=%b want 010001", flags);
            mismatched++;
        end
    endtask

    task automatic test_dwell_green();
        do_reset();
        hold(C_RED, 50);
        hold(C_YEL, 10);
        hold(C_GRN, 29);
        step(C_RED);
        compared++;
        if (flags !== 6'b100011 || tl.rounds !== 2'd0) begin
            $display("FAIL short_green: flags=%b rounds=%0d want 100011/0", flags, tl.rounds);
            mismatched++;
        end
        do_reset();
        hold(C_RED, 50);
        hold(C_YEL, 10);
        hold(C_GRN, 7);
        step(C_OFF);
        compared++;
        if (flags !== 6'b000000) begin
            $display("FAIL green_off: flags=%b want 000000", flags);
            mismatched++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(C_OFF);
        for (int r = 1; r <= 4; r++) begin
            hold(C_RED, 50);
            hold(C_YEL, 10);
            hold(C_GRN, 30);
            step(C_RED);
            if (r >= 3) begin
                compared++;
                if (tl.rounds !== 2'(r) || flags !== 6'b100000) begin
                    $display("FAIL wrap_round%0d: rounds=%0d flags=%b want %0d/100000",
                             r, tl.rounds, flags, r % 4);
                    mismatched++;
                end
            end
            hold(C_OFF, 1);
        end
    endtask

    task automatic test_mid_reset();
        step(C_RED);
        hold(C_RED, 49);
        hold(C_YEL, 5);
        rst = 1'b0;
        step(C_YEL);
        rst = 1'b1;
        compared++;
        if (flags !== 6'b000000 || tl.rounds !== 2'd0) begin
            $display("FAIL mid_reset: flags=%b rounds=%0d want 000000/0", flags, tl.rounds);
            mismatched++;
        end
        hold(C_RED, 50);
        hold(C_YEL, 10);
        compared++;
        if (flags !== 6'b010000) begin
            $display("FAIL after_reset: flags=%b want 010000", flags);
            mismatched++;
        end
        step(C_GRN);
        compared++;
        if (flags !== 6'b001000) begin
            $display("FAIL after_reset_green: flags=%b want 001000", flags);
            mismatched++;
        end
    endtask

    initial begin
        tl.light = C_OFF;
        test_reset();
        test_full_round();
        test_seq_error();
        test_dwell_red();
        test_dwell_green();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
